cpu1_oci_trace_capture: RTL
===========================

CPU1_OCI_TRACE_CAPTURE -- requirements
Module: cpu1_oci_trace_capture

Interface
REQ-001 Parameter DATA_W, default 30, SHALL set the trace-word width.
REQ-002 Parameter CNT_W, default 4, SHALL set the valid-count field width.
REQ-003 Parameter DEPTH, default 16, SHALL set the FIFO entry count; power of two, 2..256.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 dct_buffer  input  DATA_W  SHALL carry the trace data word.
REQ-007 dct_count  input  CNT_W  SHALL carry the number of valid slots in dct_buffer.
REQ-008 dct_wr  input  1  SHALL be the capture strobe for the dct_buffer/dct_count pair.
REQ-009 test_ending  input  1  SHALL request the end of capture.
REQ-010 test_has_ended  input  1  SHALL indicate the test has completed.
REQ-011 out_data  output  DATA_W+CNT_W  SHALL carry the head entry as {count, buffer}.
REQ-012 out_valid  output  1  SHALL flag that out_data holds a valid entry.
REQ-013 out_ready  input  1  SHALL be the consumer acceptance signal.
REQ-014 fill_level  output  log2(DEPTH)+1  SHALL report the number of stored entries.
REQ-015 overflow  output  1  SHALL be a sticky flag for a dropped entry.
REQ-016 done  output  1  SHALL flag that capture is finished and fully drained.

Function
REQ-017 FSM states: CAPTURE, FLUSH, DONE; reset state SHALL be CAPTURE.
REQ-018 Push SHALL occur only when the FSM is in CAPTURE, dct_wr=1, and dct_count!=0; a zero count SHALL be ignored.
REQ-019 A pushed entry SHALL become visible on out_valid on the cycle after the push (1-cycle latency, no fall-through).
REQ-020 Pop SHALL occur when out_valid=1 and out_ready=1; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 Push when full without a simultaneous pop SHALL drop the entry, leave FIFO contents unchanged, and set overflow.
REQ-022 Push when full with a simultaneous pop SHALL be accepted; fill_level SHALL be unchanged.
REQ-023 Simultaneous push and pop at any level SHALL leave fill_level unchanged.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 CAPTURE->FLUSH SHALL occur when test_ending=1; a push in that same cycle SHALL still be accepted.
REQ-026 FLUSH->DONE SHALL occur when fill_level=0 and test_has_ended=1.
REQ-027 CAPTURE->DONE SHALL occur directly when test_ending=1, test_has_ended=1, fill_level=0, and no push is pending.
REQ-028 DONE SHALL be terminal until reset; done=1 only in DONE, and all pushes SHALL be ignored in DONE.
REQ-029 fill_level SHALL never exceed DEPTH.

Reset
REQ-030 On reset_n=0: out_valid=0, out_data=0, fill_level=0, overflow=0, done=0, pointers=0, state=CAPTURE.
REQ-031 Reset mid-operation SHALL discard all stored entries immediately.
REQ-032 Release of reset_n SHALL allow a push on the first rising clock edge after release.

Configuration
REQ-033 Macro CPU1_OCI_TRACE_DROP_CNT_EN SHALL, when defined, add output drop_cnt [15:0], counting dropped entries.
REQ-034 drop_cnt SHALL saturate at 16'hFFFF and reset to 0.
REQ-035 Without CPU1_OCI_TRACE_DROP_CNT_EN, the port and counter SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-036 Single push: push (dct_buffer=30'h0ABCDEF, dct_count=4'd3) with out_ready=0 -> next cycle out_valid=1, out_data={4'd3,30'h0ABCDEF}, fill_level=1.
REQ-037 Fill and overflow: 17 pushes with out_ready=0 (DEPTH=16) -> fill_level=16, overflow=1, drop_cnt=1 (macro on), head equals the first entry.
REQ-038 Full push+pop: with FIFO full, push and pop in the same cycle -> fill_level stays 16, overflow stays 0, entry order preserved across the pointer wrap.
REQ-039 Zero-count filter: push with dct_count=0 -> fill_level unchanged, out_valid unchanged.
REQ-040 End sequence: 3 entries stored, pulse test_ending, then hold test_has_ended=1 and drain with out_ready=1 -> done=1 the cycle after the last pop; a later dct_wr is ignored.
REQ-041 Async reset: assert reset_n=0 mid-drain, between clock edges -> outputs cleared immediately, before the next clock edge; state returns to CAPTURE.

Source files
------------

// File: rtl/cpu1_oci_trace_capture.sv
// Trace capture FIFO with a CAPTURE/FLUSH/DONE controller in front of a single consumer port.
// Optional drop counter port drop_cnt is present only when CPU1_OCI_TRACE_DROP_CNT_EN is defined.
module cpu1_oci_trace_capture #(
  parameter int DATA_W = 30,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [DATA_W-1:0]          dct_buffer,
  input  logic [CNT_W-1:0]           dct_count,
  input  logic                       dct_wr,
  input  logic                       test_ending,
  input  logic                       test_has_ended,
  output logic [DATA_W+CNT_W-1:0]    out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       overflow,
  output logic                       done,
  output logic [1:0]                 dbg_state
`ifdef CPU1_OCI_TRACE_DROP_CNT_EN
  ,
  output logic [15:0]                drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_W + CNT_W;
  localparam logic [AW:0]   FILL_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0]   FILL_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_done;
  logic            r_overflow;
  logic [AW:0]     r_fill;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [EW-1:0]   r_mem [DEPTH];

  logic            w_push_req;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [AW:0]     w_fill_next;

  // Handshake: an entry transfers on any rising edge where out_valid and out_ready are both 1;
  // while out_valid=1 and out_ready=0 the head entry (out_data) is held unchanged.
  assign out_valid  = (r_fill != '0);
  assign out_data   = out_valid ? r_mem[r_rd_ptr] : '0;
  assign fill_level = r_fill;
  assign overflow   = r_overflow;
  assign done       = r_done;
  assign dbg_state  = r_state;

  assign w_push_req = (r_state == ST_CAPTURE) && dct_wr && (dct_count != '0);
  assign w_full     = (r_fill == FILL_MAX);
  assign w_pop      = out_valid && out_ready;
  // When full, a push is only taken if the head leaves in the same cycle.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  always_comb begin
    w_fill_next = r_fill;
    case ({w_push, w_pop})
      2'b10:   w_fill_next = r_fill + FILL_ONE;
      2'b01:   w_fill_next = r_fill - FILL_ONE;
      default: w_fill_next = r_fill;
    endcase
  end

  // Storage array carries no reset; out_data is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {dct_count, dct_buffer};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fill   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_fill <= w_fill_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  // Controller: done is registered alongside the state so it rises together with DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_CAPTURE;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_CAPTURE: begin
          if (test_ending) begin
            if (test_has_ended && (r_fill == '0) && !w_push_req) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          // Looking at the post-pop level lets done rise right after the final pop.
          if (test_has_ended && (w_fill_next == '0)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= ST_CAPTURE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CPU1_OCI_TRACE_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  assign drop_cnt = r_drop_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_cnt <= 16'd0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end
`endif

endmodule
